// File: rtl/led_page_scanner.sv
// Shows one byte of a 16x8 memory image on board LEDs, paging either on a
// dwell timer (AUTO) or on next/prev buttons (MANUAL).
module led_page_scanner #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] mem_flat,
  input  logic         btn_mode,
  input  logic         btn_next,
  input  logic         btn_prev,
  output logic [7:0]   led_byte,
  output logic [3:0]   led_index,
  output logic         auto_mode,
  output logic         page_tick
);

  typedef enum logic {
    S_MANUAL = 1'b0,
    S_AUTO   = 1'b1
  } mode_e;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  mode_e            state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       byte_q;
  logic             tick_q, tick_d;
  logic             mode_hist_q, next_hist_q, prev_hist_q;
  logic             mode_edge, next_edge, prev_edge;

  // History registers reset high so a button held through reset is ignored.
  assign mode_edge = btn_mode & ~mode_hist_q;
  assign next_edge = btn_next & ~next_hist_q;
  assign prev_edge = btn_prev & ~prev_hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_AUTO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_edge) begin
      state_d = (state_q == S_AUTO) ? S_MANUAL : S_AUTO;
    end
  end

  always_comb begin
    auto_mode = (state_q == S_AUTO);
  end

  // Page stepping is judged against the mode held before any toggle this cycle.
  always_comb begin
    cnt_d = '0;
    idx_d = idx_q;
    if (state_q == S_AUTO) begin
      if (cnt_q == DWELL_LAST) begin
        idx_d = idx_q + 4'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (next_edge && !prev_edge) begin
      idx_d = idx_q + 4'd1;
    end else if (prev_edge && !next_edge) begin
      idx_d = idx_q - 4'd1;
    end
    if (mode_edge) begin
      cnt_d = '0;
    end
    tick_d = (idx_d != idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      byte_q      <= '0;
      tick_q      <= 1'b0;
      mode_hist_q <= 1'b1;
      next_hist_q <= 1'b1;
      prev_hist_q <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      byte_q      <= mem_flat[{idx_q, 3'b000} +: 8];
      tick_q      <= tick_d;
      mode_hist_q <= btn_mode;
      next_hist_q <= btn_next;
      prev_hist_q <= btn_prev;
    end
  end

  assign led_byte  = byte_q;
  assign led_index = idx_q;
  assign page_tick = tick_q;

endmodule

// File: tb/tb_led_page_scanner.sv
// Scoreboard bench for led_page_scanner: a cycle model queues expected outputs
// per edge, plus directed checks at the notable points of each scenario.
module tb_led_page_scanner;

  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] mem_flat;
  logic         btn_mode, btn_next, btn_prev;
  logic [7:0]   led_byte;
  logic [3:0]   led_index;
  logic         auto_mode, page_tick;

  led_page_scanner #(.DWELL_CYCLES(D), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_flat  (mem_flat),
    .btn_mode  (btn_mode),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
    .led_byte  (led_byte),
    .led_index (led_index),
    .auto_mode (auto_mode),
    .page_tick (page_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] byt;
    logic       am;
    logic       tk;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  int   m_idx, m_cnt;
  logic [7:0] m_byte;
  logic m_auto, m_tick, pm, pn, pp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic model_edge();
    int   nidx;
    logic em, en, ep;
    exp_t e;
    if (rst) begin
      m_idx = 0; m_cnt = 0; m_byte = 8'h00; m_auto = 1'b1; m_tick = 1'b0;
      pm = 1'b1; pn = 1'b1; pp = 1'b1;
    end else begin
      em = btn_mode && !pm;
      en = btn_next && !pn;
      ep = btn_prev && !pp;
      nidx = m_idx;
      if (m_auto) begin
        if (m_cnt == D - 1) begin
          nidx  = (m_idx + 1) % 16;
          m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        m_cnt = 0;
        if (en && !ep)      nidx = (m_idx + 1) % 16;
        else if (ep && !en) nidx = (m_idx + 15) % 16;
      end
      if (em) begin
        m_auto = !m_auto;
        m_cnt  = 0;
      end
      m_byte = mem_flat[m_idx*8 +: 8];
      m_tick = (nidx != m_idx);
      m_idx  = nidx;
      pm = btn_mode; pn = btn_next; pp = btn_prev;
    end
    e.idx = 4'(m_idx);
    e.byt = m_byte;
    e.am  = m_auto;
    e.tk  = m_tick;
    sb.push_back(e);
  endtask

  // One clock edge: predict, advance, then compare just after the edge.
  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("sb_idx", 32'(led_index), 32'(e.idx));
      check("sb_byte", 32'(led_byte), 32'(e.byt));
      check("sb_auto", 32'(auto_mode), 32'(e.am));
      check("sb_tick", 32'(page_tick), 32'(e.tk));
    end
  endtask

  task automatic pulse(input int which);
    if (which == 0) btn_mode = 1'b1;
    if (which == 1) btn_next = 1'b1;
    if (which == 2) btn_prev = 1'b1;
    step();
    btn_mode = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    step();
  endtask

  initial begin
    int ticks;
    rst = 1'b1; btn_mode = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    for (int i = 0; i < 16; i++) mem_flat[i*8 +: 8] = 8'(8'h10 + i);
    mem_flat[7:0] = 8'h07; mem_flat[15:8] = 8'h03;
    mem_flat[23:16] = 8'h02; mem_flat[31:24] = 8'h01;

    // Reset state
    step(); step();
    check("rst_idx", 32'(led_index), 32'd0);
    check("rst_byte", 32'(led_byte), 32'h00);
    check("rst_auto", 32'(auto_mode), 32'd1);
    check("rst_tick", 32'(page_tick), 32'd0);

    // AUTO stepping and wrap over 64 edges
    rst = 1'b0;
    ticks = 0;
    for (int e = 1; e <= 64; e++) begin
      step();
      if (page_tick) ticks++;
      if (e == 1) check("auto_byte0", 32'(led_byte), 32'h07);
      if (e == 3) check("auto_e3_idx", 32'(led_index), 32'd0);
      if (e == 4) begin
        check("auto_e4_idx", 32'(led_index), 32'd1);
        check("auto_e4_tick", 32'(page_tick), 32'd1);
      end
      if (e == 5) begin
        check("auto_e5_byte", 32'(led_byte), 32'h03);
        check("auto_e5_tick", 32'(page_tick), 32'd0);
      end
      if (e == 64) begin
        check("wrap_idx", 32'(led_index), 32'd0);
        check("wrap_tick", 32'(page_tick), 32'd1);
      end
    end
    check("wrap_ticks", 32'(ticks), 32'd16);

    // MANUAL stepping and wrap
    btn_mode = 1'b1; step();
    check("man_auto", 32'(auto_mode), 32'd0);
    check("man_notick", 32'(page_tick), 32'd0);
    btn_mode = 1'b0; step();
    btn_prev = 1'b1; step();
    check("prev_wrap_idx", 32'(led_index), 32'd15);
    check("prev_wrap_tick", 32'(page_tick), 32'd1);
    btn_prev = 1'b0; step();
    pulse(1); pulse(1);
    check("next_twice", 32'(led_index), 32'd1);
    ticks = 0;
    btn_next = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (page_tick) ticks++;
    end
    btn_next = 1'b0; step();
    check("hold_ticks", 32'(ticks), 32'd1);
    check("hold_idx", 32'(led_index), 32'd2);

    // Simultaneous buttons
    btn_next = 1'b1; btn_prev = 1'b1; step();
    check("both_idx", 32'(led_index), 32'd2);
    check("both_tick", 32'(page_tick), 32'd0);
    btn_next = 1'b0; btn_prev = 1'b0; step();
    btn_mode = 1'b1; btn_next = 1'b1; step();
    check("mode_next_idx", 32'(led_index), 32'd3);
    check("mode_next_auto", 32'(auto_mode), 32'd1);
    btn_mode = 1'b0; btn_next = 1'b0; step();
    btn_next = 1'b1; step();
    check("auto_ignore_idx", 32'(led_index), 32'd3);
    check("auto_ignore_tick", 32'(page_tick), 32'd0);
    btn_next = 1'b0; btn_mode = 1'b1; step();
    check("back_manual", 32'(auto_mode), 32'd0);
    btn_mode = 1'b0; step();

    // Live memory update at page 5
    pulse(1); pulse(1);
    check("page5_idx", 32'(led_index), 32'd5);
    check("page5_old", 32'(led_byte), 32'h15);
    mem_flat[47:40] = 8'hA5;
    step();
    check("live_byte", 32'(led_byte), 32'hA5);

    // Reset mid-operation with a held button
    pulse(0);
    step();
    rst = 1'b1; btn_next = 1'b1;
    step(); step();
    check("mid_rst_idx", 32'(led_index), 32'd0);
    check("mid_rst_auto", 32'(auto_mode), 32'd1);
    check("mid_rst_byte", 32'(led_byte), 32'h00);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      if (e == 3) check("mid_e3_idx", 32'(led_index), 32'd0);
      if (e == 4) begin
        check("mid_e4_idx", 32'(led_index), 32'd1);
        check("mid_e4_tick", 32'(page_tick), 32'd1);
      end
    end
    btn_next = 1'b0; step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
